ahb_master: RTL

AHB_MASTER -- requirements
Module: ahb_master

---
 rtl/ahb_pkg.sv | 9 +
 rtl/ahb_master.sv | 100 ++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer-type encodings shared by ahb_master and ahb_slave.
package ahb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;
endpackage

// File: rtl/ahb_master.sv
// ahb_master: pipelined single-beat AHB-Lite master bridging a valid/ready command port
// to the bus, one transfer per cycle with overlapped address and data phases.
module ahb_master
    import ahb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [dataWidth-1:0] hwdata,
    input  logic [dataWidth-1:0] hrdata,
    input  logic                 hready
);
    htrans_e              htrans_q, htrans_d;
    logic [addrWidth-1:0] haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [dataWidth-1:0] ap_wdata_q, ap_wdata_d;
    logic                 dp_valid_q, dp_valid_d;
    logic                 dp_write_q, dp_write_d;
    logic [dataWidth-1:0] dp_wdata_q, dp_wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 ap_done;

    assign cmd_ready = hready;
    assign ap_done   = hready && htrans_q == NONSEQ;

    // Every register advances only on hready; a wait state freezes both phases.
    always_comb begin
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        if (hready) begin
            rsp_valid_d = dp_valid_q;
            rsp_write_d = dp_valid_q ? dp_write_q : rsp_write_q;
            rsp_rdata_d = (dp_valid_q && !dp_write_q) ? hrdata : rsp_rdata_q;
            dp_valid_d  = ap_done;
            dp_write_d  = ap_done ? hwrite_q : dp_write_q;
            dp_wdata_d  = (ap_done && hwrite_q) ? ap_wdata_q : dp_wdata_q;
            htrans_d    = cmd_valid ? NONSEQ : IDLE;
            haddr_d     = cmd_valid ? cmd_addr : haddr_q;
            hwrite_d    = cmd_valid ? cmd_write : hwrite_q;
            ap_wdata_d  = cmd_valid ? cmd_wdata : ap_wdata_q;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans_q    <= IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = dp_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule
